// File: rtl/temp_sampler_if.sv
// -----------------------------------------------------------------------------
// temp_sampler_if
// Sensor sample stream between a temperature sensor and temp_sampler.
//
// Signals
//   s_valid  sensor -> sampler  sample valid
//   s_data   sensor -> sampler  temperature sample, signed Q7.0
//   s_ready  sampler -> sensor  sampler accepts a sample this cycle
//
// Modports
//   master   sensor side (drives s_valid/s_data)
//   slave    sampler side (drives s_ready)
// -----------------------------------------------------------------------------
interface temp_sampler_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/temp_sampler.sv
// -----------------------------------------------------------------------------
// temp_sampler
// Acquires signed Q7.0 temperature samples, averages windows of
// N = 2^avg_log2 samples and publishes the result on T_cur with a one-cycle
// t_valid pulse. The first window after a start or after recovery from sensor
// loss also pulses init. A per-sample timeout detects sensor loss.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   start        1-cycle pulse, (re)starts acquisition, latches avg_log2
//   stop         1-cycle pulse, aborts acquisition (wins over start)
//   avg_log2     window size exponent, N = 1, 2, 4 or 8
//   timeout      max cycles between accepted samples, 0 disables
//   s            sample stream (slave side: s_valid, s_data in; s_ready out)
//   T_cur        averaged temperature, signed Q7.0, held between updates
//   t_valid      1-cycle pulse on each T_cur update
//   init         1-cycle pulse with the first T_cur after start/recovery
//   timeout_err  sensor-loss flag
// -----------------------------------------------------------------------------
module temp_sampler #(
   parameter int unsigned TO_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stop,
   input  logic [1:0]      avg_log2,
   input  logic [TO_W-1:0] timeout,
   temp_sampler_if.slave   s,
   output logic [7:0]      T_cur,
   output logic            t_valid,
   output logic            init,
   output logic            timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      LOST
   } state_e;

   state_e                   state_q, state_d;
   logic signed [10:0]       acc_q, acc_d;
   logic [2:0]               cnt_q, cnt_d;
   logic [TO_W-1:0]          to_q, to_d;
   logic [1:0]               alog_q, alog_d;
   logic [7:0]               tcur_q, tcur_d;
   logic                     tvalid_q, tvalid_d;
   logic                     init_q, init_d;
   logic                     terr_q, terr_d;

   logic                     accept;
   logic                     last;
   logic signed [10:0]       sx;
   logic signed [10:0]       sum;
   logic signed [10:0]       sum_sh;
   logic [TO_W-1:0]          to_inc;
   logic                     to_expired;

   assign s.s_ready = (state_q != IDLE);
   assign accept    = s.s_valid && (state_q != IDLE);

   // 8 samples of -128 sum to -1024, the floor of an 11-bit signed range.
   assign sx     = {{3{s.s_data[7]}}, s.s_data};
   assign sum    = acc_q + sx;
   assign sum_sh = sum >>> alog_q;

   // The incoming sample is the last of the window when cnt_q == N-1.
   assign last = ({1'b0, cnt_q} == ((4'd1 << alog_q) - 4'd1));

   // Saturate instead of wrapping so a disabled timeout never aliases to 0.
   assign to_inc     = (to_q == '1) ? to_q : to_q + TO_W'(1);
   assign to_expired = (timeout != '0) && (to_inc >= timeout);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      to_d     = to_q;
      alog_d   = alog_q;
      tcur_d   = tcur_q;
      tvalid_d = 1'b0;
      init_d   = 1'b0;
      terr_d   = terr_q;

      if (stop) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         to_d    = '0;
         terr_d  = 1'b0;
      end else if (start) begin
         state_d = FILL;
         acc_d   = '0;
         cnt_d   = '0;
         to_d    = '0;
         alog_d  = avg_log2;
         terr_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
            end
            FILL, RUN, LOST: begin
               if (accept) begin
                  // LOST keeps acc/cnt at zero, so its first sample is
                  // handled by the same path as sample 1 of a FILL window.
                  to_d   = '0;
                  terr_d = 1'b0;
                  if (last) begin
                     tcur_d   = sum_sh[7:0];
                     tvalid_d = 1'b1;
                     init_d   = (state_q != RUN);
                     state_d  = RUN;
                     acc_d    = '0;
                     cnt_d    = '0;
                  end else begin
                     acc_d   = sum;
                     cnt_d   = cnt_q + 3'd1;
                     state_d = (state_q == LOST) ? FILL : state_q;
                  end
               end else if (state_q != LOST) begin
                  to_d = to_inc;
                  if (to_expired) begin
                     state_d = LOST;
                     terr_d  = 1'b1;
                     acc_d   = '0;
                     cnt_d   = '0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         to_q     <= '0;
         alog_q   <= '0;
         tcur_q   <= '0;
         tvalid_q <= 1'b0;
         init_q   <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         alog_q   <= alog_d;
         tcur_q   <= tcur_d;
         tvalid_q <= tvalid_d;
         init_q   <= init_d;
         terr_q   <= terr_d;
      end
   end

   assign T_cur       = tcur_q;
   assign t_valid     = tvalid_q;
   assign init        = init_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_temp_sampler.sv
// -----------------------------------------------------------------------------
// tb_temp_sampler
// Scoreboard bench for temp_sampler. Stimulus updates a window-level reference
// model on every clock and pushes expected {T_cur, init} for each completed
// window; a negedge monitor pops and compares whenever t_valid is seen.
// -----------------------------------------------------------------------------
module tb_temp_sampler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  avg_log2 = 2'd0;
   logic [15:0] timeout = 16'd0;
   logic [7:0]  T_cur;
   logic        t_valid;
   logic        init;
   logic        timeout_err;

   temp_sampler_if sif ();

   temp_sampler #(.TO_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .avg_log2    (avg_log2),
      .timeout     (timeout),
      .s           (sif),
      .T_cur       (T_cur),
      .t_valid     (t_valid),
      .init        (init),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int tcur;
      bit init;
   } exp_t;

   exp_t exp_q[$];
   int   win[$];
   int   m_mode  = 0;   // 0 idle, 1 acquiring, 2 sensor lost
   bit   m_first = 1'b0;
   int   m_n     = 1;
   int   m_idle  = 0;
   int   m_tcur  = 0;
   bit   m_terr  = 1'b0;
   bit   m_ready = 1'b0;
   bit   mon_en  = 1'b0;

   function automatic int floor_avg(input int s, input int n);
      int q;
      q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic model(input bit r, input bit st, input bit sp, input bit v,
                        input logic [7:0] d);
      int   sum;
      exp_t e;
      if (!r) begin
         m_mode = 0; m_tcur = 0; m_terr = 1'b0; win.delete();
      end else if (sp) begin
         m_mode = 0; m_terr = 1'b0; win.delete();
      end else if (st) begin
         m_mode = 1; m_first = 1'b1; m_n = 1 << avg_log2;
         m_idle = 0; m_terr = 1'b0; win.delete();
      end else if (m_mode != 0) begin
         if (v) begin
            win.push_back(int'($signed(d)));
            m_idle = 0;
            m_terr = 1'b0;
            if (m_mode == 2) begin
               m_mode = 1; m_first = 1'b1;
            end
            if (win.size() == m_n) begin
               sum = 0;
               foreach (win[i]) sum += win[i];
               e.tcur = floor_avg(sum, m_n);
               e.init = m_first;
               exp_q.push_back(e);
               m_tcur  = e.tcur;
               m_first = 1'b0;
               win.delete();
            end
         end else if (m_mode == 1) begin
            m_idle++;
            if (timeout != 0 && m_idle >= int'(timeout)) begin
               m_mode = 2; m_terr = 1'b1; win.delete();
            end
         end
      end
      m_ready = (m_mode != 0);
   endtask

   task automatic step(input bit r, input bit st, input bit sp, input bit v,
                       input logic [7:0] d);
      rst_n = r; start = st; stop = sp;
      sif.s_valid = v; sif.s_data = d;
      @(posedge clk);
      model(r, st, sp, v, d);
      #1;
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic sample(input int x);
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'(x));
   endtask

   task automatic do_start(input logic [1:0] a);
      avg_log2 = a;
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (t_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_t_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("t_cur", int'($signed(T_cur)), e.tcur);
               chk("init", int'(init), int'(e.init));
            end
         end else begin
            if (exp_q.size() != 0) begin
               chk("missing_t_valid", 0, 1);
               exp_q.delete();
            end
            chk("init_without_t_valid", int'(init), 0);
         end
         chk("t_cur_hold", int'($signed(T_cur)), m_tcur);
         chk("s_ready", int'(sif.s_ready), int'(m_ready));
         chk("timeout_err", int'(timeout_err), int'(m_terr));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int dens;
      sif.s_valid = 1'b0;
      sif.s_data  = 8'd0;

      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("rst_t_cur", int'(T_cur), 0);
      chk("rst_t_valid", int'(t_valid), 0);
      chk("rst_init", int'(init), 0);
      chk("rst_s_ready", int'(sif.s_ready), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      mon_en = 1'b1;
      idle_step();

      // Window of 4, then a second window without init
      timeout = 16'd0;
      do_start(2'd2);
      sample(10); sample(11); sample(12);
      avg_log2 = 2'd0;    // mid-run change must be ignored
      sample(13);
      chk("avg4_t_cur", int'($signed(T_cur)), 11);
      chk("avg4_t_valid", int'(t_valid), 1);
      chk("avg4_init", int'(init), 1);
      repeat (4) sample(20);
      chk("avg4b_t_cur", int'($signed(T_cur)), 20);
      chk("avg4b_init", int'(init), 0);

      // Negative floor
      do_start(2'd1);
      sample(-3); sample(-4);
      chk("floor_neg", int'($signed(T_cur)), -4);

      // Extremes with window of 8
      do_start(2'd3);
      repeat (8) sample(-128);
      chk("min_avg8", int'($signed(T_cur)), -128);
      repeat (8) sample(127);
      chk("max_avg8", int'($signed(T_cur)), 127);

      // Timeout to LOST and recovery
      timeout = 16'd5;
      repeat (4) idle_step();
      chk("to_before", int'(timeout_err), 0);
      idle_step();
      chk("to_lost", int'(timeout_err), 1);
      idle_step();
      sample(40);
      chk("to_cleared", int'(timeout_err), 0);
      repeat (7) sample(40);
      chk("recover_init", int'(init), 1);
      chk("recover_t_cur", int'($signed(T_cur)), 40);

      // Sample on the timeout cycle wins
      repeat (4) idle_step();
      sample(1);
      chk("to_race_err", int'(timeout_err), 0);
      repeat (4) idle_step();
      chk("to_race_still_run", int'(timeout_err), 0);

      // start+stop from IDLE
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      chk("start_stop_idle", int'(sif.s_ready), 0);

      // Reset mid-window
      timeout = 16'd0;
      do_start(2'd2);
      sample(100); sample(100);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("rst_mid_ready", int'(sif.s_ready), 0);
      idle_step();
      do_start(2'd2);
      sample(1); sample(2); sample(3); sample(4);
      chk("post_rst_t_cur", int'($signed(T_cur)), 2);
      chk("post_rst_init", int'(init), 1);

      // Randomized traffic
      dens = 70;
      for (int c = 0; c < 4000; c++) begin
         bit r, st, sp, v;
         int x;
         r  = ($urandom_range(0, 499) != 0);
         sp = ($urandom_range(0, 79) == 0);
         st = ($urandom_range(0, 59) == 0) || (!m_ready && $urandom_range(0, 5) == 0);
         if (st) begin
            avg_log2 = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
               0: timeout = 16'd0;
               1: timeout = 16'd2;
               2: timeout = 16'd5;
               default: timeout = 16'd9;
            endcase
            dens = int'($urandom_range(20, 95));
         end
         v = ($urandom_range(0, 99) < dens);
         case ($urandom_range(0, 5))
            0: x = -128;
            1: x = 127;
            default: x = int'($urandom_range(0, 255)) - 128;
         endcase
         step(r, st, sp, v, 8'(x));
      end

      repeat (3) idle_step();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
